// File: rtl/bus_copier_if.sv
// Common memory-bus signal set between one initiator (master) and the responder side (slave).
interface bus_copier_if;
   logic [31:0] address_out;
   logic        read_out;
   logic        write_out;
   logic [3:0]  write_mask_out;
   logic [31:0] write_value_out;
   logic [31:0] read_value_in;
   logic        ready_in;
   logic        fault_in;

   modport master (
      output address_out, read_out, write_out, write_mask_out, write_value_out,
      input  read_value_in, ready_in, fault_in
   );

   modport slave (
      input  address_out, read_out, write_out, write_mask_out, write_value_out,
      output read_value_in, ready_in, fault_in
   );
endinterface

// File: rtl/bus_copier.sv
// Bus initiator copying count words src->dst; 2 cycles/word at zero wait plus start and DONE cycles.
// Each access is held stable until ready_in; all bus outputs come straight from registers.
module bus_copier #(
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start_in,
   input  logic [31:0]            src_in,
   input  logic [31:0]            dst_in,
   input  logic [COUNT_WIDTH-1:0] count_in,
   output logic                   busy_out,
   output logic                   done_out,
   output logic                   fault_out,
   bus_copier_if.master           bus
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

   state_t                 state_q;
   logic [31:0]            src_q, dst_q, buf_q, addr_q;
   logic [COUNT_WIDTH-1:0] remain_q;
   logic                   read_q, write_q, busy_q, done_q, fault_q;

   logic [31:0]            src_d, dst_d;
   logic [COUNT_WIDTH-1:0] remain_d;

   // Pointers wrap naturally at 2^32.
   assign src_d    = src_q + 32'd4;
   assign dst_d    = dst_q + 32'd4;
   assign remain_d = remain_q - 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         src_q    <= '0;
         dst_q    <= '0;
         buf_q    <= '0;
         addr_q   <= '0;
         remain_q <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_in) begin
                  src_q    <= src_in & ~32'h3;
                  dst_q    <= dst_in & ~32'h3;
                  remain_q <= count_in;
                  fault_q  <= 1'b0;
                  if (count_in == '0) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     busy_q  <= 1'b1;
                     read_q  <= 1'b1;
                     addr_q  <= src_in & ~32'h3;
                     state_q <= S_READ;
                  end
               end
            end
            S_READ: begin
               if (bus.ready_in) begin
                  read_q <= 1'b0;
                  if (bus.fault_in) begin
                     fault_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     buf_q   <= bus.read_value_in;
                     write_q <= 1'b1;
                     addr_q  <= dst_q;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (bus.ready_in) begin
                  write_q <= 1'b0;
                  if (bus.fault_in) begin
                     fault_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     src_q    <= src_d;
                     dst_q    <= dst_d;
                     remain_q <= remain_d;
                     if (remain_d == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        read_q  <= 1'b1;
                        addr_q  <= src_d;
                        state_q <= S_READ;
                     end
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_out            = busy_q;
   assign done_out            = done_q;
   assign fault_out           = fault_q;
   assign bus.address_out     = addr_q;
   assign bus.read_out        = read_q;
   assign bus.write_out       = write_q;
   assign bus.write_mask_out  = {4{write_q}};
   assign bus.write_value_out = buf_q;

endmodule

// File: doc/bus_copier.md
# bus_copier

Memory-bus initiator that copies a block of 32-bit words from a source address to a destination address without CPU involvement. Typical use: copying an image from SPI flash (0x01xxxxxx) into RAM (0x10xxxxxx) before or alongside CPU execution. It drives the same common memory-bus signal set as the CPU ports and connects as an additional initiator behind the bus arbiter. It is the initiator counterpart to the existing responders (ram, flash, uart, timer).

## Interface

Parameters:
- COUNT_WIDTH, default 16: width of the word-count input and the internal remaining-word counter.

Ports:
- clk  in  1  system clock (pll_clk domain); single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- start_in  in  1  one-cycle request; sampled only in IDLE.
- src_in  in  32  source byte address; bits [1:0] ignored (treated as 0).
- dst_in  in  32  destination byte address; bits [1:0] ignored.
- count_in  in  COUNT_WIDTH  number of 32-bit words to copy.
- busy_out  out  1  high from the cycle after an accepted start until DONE.
- done_out  out  1  one-cycle pulse at completion, whether normal or faulted.
- fault_out  out  1  sticky; set on a faulted access, cleared by the next accepted start.
- address_out  out  32  bus address, always word-aligned.
- read_out  out  1  bus read request.
- write_out  out  1  bus write request.
- read_value_in  in  32  bus read data; valid when ready_in=1.
- write_mask_out  out  4  4'b1111 during write, 4'b0000 otherwise.
- write_value_out  out  32  bus write data.
- ready_in  in  1  access complete this cycle.
- fault_in  in  1  access faulted; qualified by ready_in.

## Operation

State machine: IDLE, READ, WRITE, DONE.

- **IDLE**
  - All bus requests are low.
  - On start_in=1, latch src, dst and count, and clear fault_out.
  - If count_in=0, go to DONE; no bus access is made.
  - Otherwise go to READ.
- **READ**
  - Drive read_out=1 and address_out=src_ptr.
  - Hold both stable until ready_in=1.
  - On ready_in & !fault_in: latch read_value_in into the data buffer and go to WRITE.
  - On ready_in & fault_in: set fault_out and go to DONE.
- **WRITE**
  - Drive write_out=1, address_out=dst_ptr, write_mask_out=4'b1111 and write_value_out=buffer.
  - Hold all of these until ready_in=1.
  - On ready_in & fault_in: set fault_out and go to DONE.
  - On ready_in & !fault_in:
    - Update src_ptr+=4, dst_ptr+=4, remaining-=1.
    - If the decremented remaining is 0, go to DONE; otherwise go to READ.
- **DONE**
  - Pulse done_out for one cycle, then go to IDLE.

Rules:
- Pointers wrap modulo 2^32: 0xFFFFFFFC+4 → 0x00000000. No error is raised on wrap.
- start_in is ignored in READ, WRITE and DONE.
- read_out and write_out are never high in the same cycle.
- Bus outputs are decoded from registered state and registers only; there is no combinational path from ready_in to any output.
- Overlapping source/destination regions are copied strictly in ascending word order; no overlap detection is done.

Reset values (reset_n=0, asynchronous):
- state=IDLE.
- busy_out=0, done_out=0, fault_out=0.
- read_out=0, write_out=0, write_mask_out=0, address_out=0, write_value_out=0.
- Internal pointers, counter and buffer=0.

Reset asserted mid-transfer aborts immediately. The outstanding bus request drops asynchronously, and no done_out pulse is produced.

## Timing

- Start acceptance: start_in high in IDLE at edge N; read_out is high after edge N; busy_out is high after edge N.
- With a zero-wait responder (ready_in in the same cycle as the request), each word costs 2 cycles (READ, WRITE).
- An L-cycle responder latency adds L cycles per access.
- Total for C words at zero wait: 1 (start) + 2C + 1 (DONE) cycles until IDLE.
- done_out is high exactly in the DONE cycle; busy_out is low in that cycle.
- count_in=0: done_out pulses in the cycle after start, with no read or write.
- A faulted access terminates in the same cycle ready_in/fault_in is seen; the next cycle is DONE.
- The remaining counter is COUNT_WIDTH wide. The maximum copy is 2^COUNT_WIDTH−1 words.

## Test plan

- **Basic copy:** src=0x01000000, dst=0x10000000, count=4, zero-wait memory model preloaded with 0x11111111..0x44444444 → dst holds the same 4 words. Exactly 4 reads and 4 writes with write_mask_out=4'b1111. done_out pulses at cycle 10 after start.
- **Wait states:** same copy with ready_in delayed 2 cycles on every access → identical data. Address, read_out/write_out and write_value_out are stable throughout each wait. Completion occurs at cycle 26.
- **Zero count:** count=0 → no read_out/write_out ever asserted; done_out pulses 1 cycle after start; fault_out=0.
- **Fault:** count=4, fault_in asserted with ready_in on the 3rd read → exactly 2 words written; fault_out=1 after the fault; done_out pulses. The next start with count=1 clears fault_out and copies normally.
- **Reset mid-transfer:** reset_n low during the 2nd WRITE wait → all outputs 0 asynchronously; no done_out pulse. After release, state is IDLE; a new start of count=2 completes correctly.
- **Busy start and wrap:** start asserted again while busy → ignored. A copy with src=0xFFFFFFF8, count=3 → reads 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000 in order.
